// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the fetch stage: state encoding, IF/ID payload and bubble.
package instruction_fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0000_0000, valid: 1'b0};

endpackage

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register: bubble has priority over load; neither asserted means hold.
module instruction_fetch_unit_if_id_register
  import instruction_fetch_unit_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        i_load,
  input  logic        i_bubble,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc_plus4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  ifid_t r_ifid;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_ifid <= IFID_BUBBLE;
    end else if (i_bubble) begin
      r_ifid <= IFID_BUBBLE;
    end else if (i_load) begin
      r_ifid <= '{instr: i_instr, pc_plus4: i_pc_plus4, valid: 1'b1};
    end
  end

  assign o_instr    = r_ifid.instr;
  assign o_pc_plus4 = r_ifid.pc_plus4;
  assign o_valid    = r_ifid.valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: owns the PC, drives instruction memory, and fills IF/ID with
// stall, flush, redirect and out-of-range halt handling.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_DEPTH = 128
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] Address,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        Halted,
  output logic [31:0] FetchCount
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] r_fetch_count;
  logic            w_out_of_range;
  logic            w_load;
  logic            w_bubble;
  logic            w_unused_tgt;

  assign w_pc_plus4     = r_pc + 32'd4;
  assign w_out_of_range = (32'(r_pc[31:2]) >= IMEM_DEPTH);
  assign w_unused_tgt   = |RedirectTarget[1:0];

  // State and PC registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Next state, next PC and IF/ID controls, highest priority first
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_load      = 1'b0;
    w_bubble    = 1'b0;
    if (Redirect) begin
      w_pc_nxt    = {RedirectTarget[31:2], 2'b00};
      w_state_nxt = ST_RUN;
      w_bubble    = 1'b1;
    end else if (Stall) begin
      w_bubble = Flush;
    end else begin
      case (r_state)
        ST_HALT: begin
          w_bubble = 1'b1;
        end
        default: begin
          if (w_out_of_range) begin
            w_state_nxt = ST_HALT;
            w_bubble    = 1'b1;
          end else begin
            w_pc_nxt = w_pc_plus4;
            w_bubble = Flush;
            w_load   = !Flush;
          end
        end
      endcase
    end
  end

  // Counts only fresh valid writes into IF/ID
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_fetch_count <= 32'd0;
    end else if (w_load) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  instruction_fetch_unit_if_id_register u_if_id (
    .Clk        (Clk),
    .Rst        (Rst),
    .i_load     (w_load),
    .i_bubble   (w_bubble),
    .i_instr    (Instruction),
    .i_pc_plus4 (w_pc_plus4),
    .o_instr    (IFID_Instruction),
    .o_pc_plus4 (IFID_PCPlus4),
    .o_valid    (IFID_Valid)
  );

  assign Address    = r_pc;
  assign Halted     = (r_state == ST_HALT);
  assign FetchCount = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a 128-word and a 4-word instance against a rule-level model.
module tb_instruction_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic        halted;
    logic [31:0] ins;
    logic [31:0] p4;
    logic        v;
    logic [31:0] cnt;
  } mdl_t;

  logic        Clk;
  logic        Rst;
  logic [31:0] mem [128];

  logic        stall_a, flush_a, redir_a, stall_b, flush_b, redir_b;
  logic [31:0] tgt_a, tgt_b;
  logic [31:0] inst_a, inst_b, addr_a, addr_b, ins_a, ins_b, p4_a, p4_b, cnt_a, cnt_b;
  logic        v_a, v_b, halt_a, halt_b;

  mdl_t ma, mb, na, nb;
  int   n_checks = 0;
  int   n_errors = 0;
  logic cmp_en   = 1'b0;

  assign inst_a = (addr_a[31:2] < 30'd128) ? mem[addr_a[8:2]] : 32'hBAD0_0000;
  assign inst_b = (addr_b[31:2] < 30'd128) ? mem[addr_b[8:2]] : 32'hBAD0_0000;

  instruction_fetch_unit #(.RESET_PC(32'h0), .IMEM_DEPTH(128)) dut_a (
    .Clk(Clk), .Rst(Rst), .Instruction(inst_a), .Stall(stall_a), .Flush(flush_a),
    .Redirect(redir_a), .RedirectTarget(tgt_a), .Address(addr_a),
    .IFID_Instruction(ins_a), .IFID_PCPlus4(p4_a), .IFID_Valid(v_a),
    .Halted(halt_a), .FetchCount(cnt_a)
  );

  instruction_fetch_unit #(.RESET_PC(32'h0), .IMEM_DEPTH(4)) dut_b (
    .Clk(Clk), .Rst(Rst), .Instruction(inst_b), .Stall(stall_b), .Flush(flush_b),
    .Redirect(redir_b), .RedirectTarget(tgt_b), .Address(addr_b),
    .IFID_Instruction(ins_b), .IFID_PCPlus4(p4_b), .IFID_Valid(v_b),
    .Halted(halt_b), .FetchCount(cnt_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return (a[31:2] < 30'd128) ? mem[a[8:2]] : 32'hBAD0_0000;
  endfunction

  function automatic mdl_t m_reset();
    mdl_t m;
    m = '0;
    return m;
  endfunction

  // One edge of the fetch rules, applied in priority order
  function automatic mdl_t m_step(input mdl_t m, input logic st, input logic fl,
                                  input logic rd, input logic [31:0] tg, input int unsigned depth);
    mdl_t n;
    n = m;
    if (rd) begin
      n.pc = {tg[31:2], 2'b00};
      n.halted = 1'b0;
      n.ins = 32'h0; n.p4 = 32'h0; n.v = 1'b0;
    end else if (st) begin
      if (fl) begin n.ins = 32'h0; n.p4 = 32'h0; n.v = 1'b0; end
    end else if (m.halted) begin
      n.ins = 32'h0; n.p4 = 32'h0; n.v = 1'b0;
    end else if (32'(m.pc[31:2]) >= depth) begin
      n.halted = 1'b1;
      n.ins = 32'h0; n.p4 = 32'h0; n.v = 1'b0;
    end else begin
      n.pc = m.pc + 32'd4;
      if (fl) begin
        n.ins = 32'h0; n.p4 = 32'h0; n.v = 1'b0;
      end else begin
        n.ins = mem_rd(m.pc); n.p4 = m.pc + 32'd4; n.v = 1'b1;
        n.cnt = m.cnt + 32'd1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    na = m_step(ma, stall_a, flush_a, redir_a, tgt_a, 128);
    nb = m_step(mb, stall_b, flush_b, redir_b, tgt_b, 4);
    @(posedge Clk);
    ma = na;
    mb = nb;
    #1;
  endtask

  task automatic chk_a(input string nm, input logic [31:0] pc, input logic [31:0] i,
                       input logic [31:0] p4, input logic v, input logic [31:0] c);
    chk({nm, ".addr"}, addr_a, pc);
    chk({nm, ".ins"},  ins_a, i);
    chk({nm, ".p4"},   p4_a, p4);
    chk({nm, ".v"},    32'(v_a), 32'(v));
    chk({nm, ".cnt"},  cnt_a, c);
  endtask

  task automatic chk_b(input string nm, input logic [31:0] pc, input logic [31:0] i,
                       input logic [31:0] p4, input logic v, input logic h, input logic [31:0] c);
    chk({nm, ".addr"}, addr_b, pc);
    chk({nm, ".ins"},  ins_b, i);
    chk({nm, ".p4"},   p4_b, p4);
    chk({nm, ".v"},    32'(v_b), 32'(v));
    chk({nm, ".halt"}, 32'(halt_b), 32'(h));
    chk({nm, ".cnt"},  cnt_b, c);
  endtask

  // Every-cycle comparison of both instances against the model
  always @(negedge Clk) begin
    if (cmp_en) begin
      chk("cyc_a.addr", addr_a, ma.pc);
      chk("cyc_a.ins",  ins_a,  ma.ins);
      chk("cyc_a.p4",   p4_a,   ma.p4);
      chk("cyc_a.v",    32'(v_a), 32'(ma.v));
      chk("cyc_a.halt", 32'(halt_a), 32'(ma.halted));
      chk("cyc_a.cnt",  cnt_a,  ma.cnt);
      chk("cyc_b.addr", addr_b, mb.pc);
      chk("cyc_b.ins",  ins_b,  mb.ins);
      chk("cyc_b.p4",   p4_b,   mb.p4);
      chk("cyc_b.v",    32'(v_b), 32'(mb.v));
      chk("cyc_b.halt", 32'(halt_b), 32'(mb.halted));
      chk("cyc_b.cnt",  cnt_b,  mb.cnt);
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 | 32'(i);
    mem[0] = 32'hAAAA_0000; mem[1] = 32'hBBBB_0001;
    mem[2] = 32'hCCCC_0002; mem[3] = 32'hDDDD_0003;
    Rst = 1'b0;
    stall_a = 0; flush_a = 0; redir_a = 0; tgt_a = 32'h0;
    stall_b = 0; flush_b = 0; redir_b = 0; tgt_b = 32'h0;
    ma = m_reset(); mb = m_reset();
    #12;
    Rst = 1'b1;
    cmp_en = 1'b1;
    chk_a("reset_a", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    chk_b("reset_b", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

    tick(); chk_a("fetch_A", 32'h4, 32'hAAAA_0000, 32'h4, 1'b1, 32'd1);
    tick(); chk_a("fetch_B", 32'h8, 32'hBBBB_0001, 32'h8, 1'b1, 32'd2);
    stall_a = 1;
    tick(); chk_a("stall1", 32'h8, 32'hBBBB_0001, 32'h8, 1'b1, 32'd2);
    tick(); chk_a("stall2", 32'h8, 32'hBBBB_0001, 32'h8, 1'b1, 32'd2);
    chk_b("b_word3", 32'h10, 32'hDDDD_0003, 32'h10, 1'b1, 1'b0, 32'd4);
    stall_a = 0;
    tick(); chk_a("fetch_C", 32'hC, 32'hCCCC_0002, 32'hC, 1'b1, 32'd3);
    chk_b("b_halt", 32'h10, 32'h0, 32'h0, 1'b0, 1'b1, 32'd4);
    tick(); tick();
    chk_a("pc20", 32'h14, 32'h1000_0004, 32'h14, 1'b1, 32'd5);
    chk_b("b_halt_hold", 32'h10, 32'h0, 32'h0, 1'b0, 1'b1, 32'd4);

    redir_a = 1; tgt_a = 32'h1D; stall_a = 1; flush_a = 1;
    redir_b = 1; tgt_b = 32'h0;
    tick(); chk_a("redir", 32'h1C, 32'h0, 32'h0, 1'b0, 32'd5);
    chk_b("b_unhalt", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd4);
    redir_a = 0; stall_a = 0; flush_a = 0; redir_b = 0;
    tick(); chk_a("after_redir", 32'h20, 32'h1000_0007, 32'h20, 1'b1, 32'd6);
    chk_b("b_word0", 32'h4, 32'hAAAA_0000, 32'h4, 1'b1, 1'b0, 32'd5);

    redir_a = 1; tgt_a = 32'h4; redir_b = 1; tgt_b = 32'h10;
    tick(); chk_a("redir4", 32'h4, 32'h0, 32'h0, 1'b0, 32'd6);
    chk_b("b_redir_oor", 32'h10, 32'h0, 32'h0, 1'b0, 1'b0, 32'd5);
    redir_a = 0; redir_b = 0; flush_a = 1;
    tick(); chk_a("flush", 32'h8, 32'h0, 32'h0, 1'b0, 32'd6);
    chk_b("b_oor_halt", 32'h10, 32'h0, 32'h0, 1'b0, 1'b1, 32'd5);
    flush_a = 0;

    #2;
    Rst = 1'b0;
    ma = m_reset(); mb = m_reset();
    #1;
    chk_b("async_rst_b", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    chk_a("async_rst_a", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    chk("async_rst_a.halt", 32'(halt_a), 32'd0);
    #4;
    Rst = 1'b1;
    tick(); chk_a("post_rst", 32'h4, 32'hAAAA_0000, 32'h4, 1'b1, 32'd1);
    tick(); tick();
    cmp_en = 1'b0;
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage of the MIPS pipeline. It sits directly upstream of the instruction memory. It owns the program counter and drives the word-aligned fetch address to the instruction memory, which reads combinationally. It captures the returned instruction with PC+4 into the IF/ID pipeline register, and handles hazard-unit stalls, flushes, branch/jump redirects and an out-of-range halt.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
IMEM_DEPTH, 128, number of 32-bit words in instruction memory; a PC word index >= IMEM_DEPTH is out of range.

Ports:
Clk  input  1  system clock; all state updates on the rising edge.
Rst  input  1  asynchronous, active-low reset.
Instruction  input  32  instruction word returned by instruction memory for Address, same cycle.
Stall  input  1  hazard unit: hold PC and IF/ID.
Flush  input  1  force a bubble into IF/ID on this edge.
Redirect  input  1  taken branch/jump/jr resolved in ID.
RedirectTarget  input  32  new PC when Redirect=1.
Address  output  32  current PC to instruction memory; always word-aligned.
IFID_Instruction  output  32  latched instruction.
IFID_PCPlus4  output  32  latched PC+4 of that instruction.
IFID_Valid  output  1  IF/ID holds a real instruction.
Halted  output  1  fetch stopped, PC ran out of range.
FetchCount  output  32  number of valid instructions written into IF/ID since reset.

Behaviour:
- Reset (Rst=0, asynchronous, any time):
  - PC=RESET_PC; state=RUN; Halted=0; FetchCount=0.
  - IF/ID=bubble. Bubble means IFID_Instruction=32'h0 (nop), IFID_PCPlus4=0, IFID_Valid=0.
  - Reset mid-operation discards everything in flight.
- Address = PC (registered, no combinational path from inputs). Instruction is consumed in the same cycle.
- States: RUN, HALT. Halted=1 iff state==HALT.
- Per rising edge with Rst=1, evaluate in this priority order:
  1. Redirect=1:
     - PC <= {RedirectTarget[31:2],2'b00}; target bits [1:0] are ignored.
     - IF/ID <= bubble; state <= RUN, which also exits HALT. Redirect overrides both Stall and Flush.
  2. Stall=1:
     - PC holds.
     - IF/ID holds, unless Flush=1, in which case IF/ID <= bubble.
  3. state==HALT: PC holds; IF/ID <= bubble.
  4. RUN with PC[31:2] >= IMEM_DEPTH: state <= HALT; PC holds; IF/ID <= bubble.
  5. RUN, in range:
     - IF/ID <= {Instruction, PC+4, Valid=1}; PC <= PC+4.
     - If Flush=1, IF/ID <= bubble instead, but PC still advances.
- FetchCount increments by 1 exactly on edges where IF/ID is written with Valid=1. Held IF/ID contents under stall are not recounted. Wraps modulo 2^32.
- PC+4 arithmetic is 32-bit unsigned and wraps at 0xFFFF_FFFC→0. In practice the halt check fires first for any IMEM_DEPTH < 2^30.
- Latency: an instruction at PC appears on IF/ID outputs one edge after Address=PC.
- A redirect target that is itself out of range enters RUN, then halts on the next edge with no valid fetch.

Decomposition:
- Shared package: NOP_INSTR=32'h0; state encoding {RUN, HALT}; bubble constant; default RESET_PC.
- One natural sub-module: if_id_register, containing the hold, bubble and load controls plus the Valid bit. PC/next-PC logic and the state machine stay in the top.

Test Plan:
- Reset release with RESET_PC=0 and memory words 0..3 = A,B,C,D:
  - Address steps 0,4,8,12 on consecutive edges.
  - IF/ID shows (A,4,1), (B,8,1), (C,12,1).
  - FetchCount reaches 3.
- Stall=1 for 2 cycles at PC=8:
  - Address stays 8 and IF/ID holds (B,8,1) for both cycles.
  - FetchCount unchanged.
  - After release, IF/ID=(C,12,1).
- Redirect=1 with RedirectTarget=32'h1D (Stall=1, Flush=1 also asserted) at PC=20: next PC=32'h1C, IF/ID=bubble; next edge IF/ID=(mem[7],32'h20,1).
- IMEM_DEPTH=4, free-run from 0:
  - After word 3 is fetched, PC=16 leads to Halted=1, Address stays 16, IF/ID=bubble.
  - Redirect to 0 clears Halted; word 0 is fetched the following edge.
- Flush=1 alone at PC=4: IF/ID=bubble, PC advances to 8, FetchCount unchanged.
- Assert Rst=0 asynchronously mid-cycle while Halted=1 and FetchCount=5: all outputs immediately return to reset values (Address=RESET_PC, Halted=0, FetchCount=0, IFID_Valid=0).
